// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: memory opcodes, FSM encoding,
// internal memory-op classification and the bus/address error fill value.
package mem_stage_pkg;

   localparam logic [5:0] OP_RFORM = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JALR  = 6'h09;

   localparam logic [31:0] BAD_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [3:0] {
      MOP_NONE,
      MOP_LB,
      MOP_LH,
      MOP_LW,
      MOP_LBU,
      MOP_LHU,
      MOP_SB,
      MOP_SH,
      MOP_SW
   } mop_t;

   function automatic mop_t decode_mop(input logic [5:0] opc);
      case (opc)
         OP_LB:   return MOP_LB;
         OP_LH:   return MOP_LH;
         OP_LW:   return MOP_LW;
         OP_LBU:  return MOP_LBU;
         OP_LHU:  return MOP_LHU;
         OP_SB:   return MOP_SB;
         OP_SH:   return MOP_SH;
         OP_SW:   return MOP_SW;
         default: return MOP_NONE;
      endcase
   endfunction

   function automatic logic mop_is_store(input mop_t m);
      return (m == MOP_SB) || (m == MOP_SH) || (m == MOP_SW);
   endfunction

   // Byte accesses can never be misaligned; halves need addr[0]=0, words addr[1:0]=0.
   function automatic logic mop_misaligned(input mop_t m, input logic [1:0] lo);
      case (m)
         MOP_LH, MOP_LHU, MOP_SH: return lo[0];
         MOP_LW, MOP_SW:          return (lo != 2'b00);
         default:                 return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane steering for the MEM stage: store byte enables and lane
// replication, plus load lane extraction with sign or zero extension.
module mem_align
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  mop_t              st_op,
   input  logic [1:0]        st_addr_lo,
   input  logic [DATA_W-1:0] st_data,
   output logic [3:0]        st_be,
   output logic [DATA_W-1:0] st_wdata,
   input  mop_t              ld_op,
   input  logic [1:0]        ld_addr_lo,
   input  logic [DATA_W-1:0] ld_rdata,
   output logic [DATA_W-1:0] ld_data
);

   function automatic logic signed [31:0] sext8(input logic signed [7:0] b);
      logic signed [31:0] r;
      r = b;
      return r;
   endfunction

   function automatic logic signed [31:0] sext16(input logic signed [15:0] h);
      logic signed [31:0] r;
      r = h;
      return r;
   endfunction

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign lane_b = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
   assign lane_h = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

   always_comb begin
      st_be    = 4'b0000;
      st_wdata = st_data;
      case (st_op)
         MOP_LB, MOP_LBU, MOP_SB: begin
            st_be    = 4'b0001 << st_addr_lo;
            st_wdata = {4{st_data[7:0]}};
         end
         MOP_LH, MOP_LHU, MOP_SH: begin
            st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
         end
         MOP_LW, MOP_SW: st_be = 4'b1111;
         default:        st_be = 4'b0000;
      endcase
   end

   always_comb begin
      ld_data = ld_rdata;
      case (ld_op)
         MOP_LB:  ld_data = sext8(lane_b);
         MOP_LBU: ld_data = {24'h000000, lane_b};
         MOP_LH:  ld_data = sext16(lane_h);
         MOP_LHU: ld_data = {16'h0000, lane_h};
         default: ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: decodes loads/stores, runs a single-outstanding bus
// request with timeout, and selects the write-back value.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int DATA_W      = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] Ins,
   input  logic [DATA_W-1:0] Result,
   input  logic [DATA_W-1:0] Rdata2,
   input  logic [DATA_W-1:0] nextPC,
   output logic [DATA_W-1:0] Wdata,
   output logic              Stall,
   output logic              AddrErr,
   output logic              BusErr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_be,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [5:0]        opc, funct;
   mop_t              mop_p0;
   logic              misaligned_p0, is_link_p0, start_p0;
   logic [3:0]        be_p0;
   logic [DATA_W-1:0] wdata_p0;
   mop_t              op_p1;
   logic [1:0]        addr_lo_p1;
   logic [DATA_W-1:0] rdata_p2;
   logic              bus_err_p2;
   logic [DATA_W-1:0] ld_data;
   logic              timeout;
   logic              unused_ins;

   assign opc        = Ins[31:26];
   assign funct      = Ins[5:0];
   assign unused_ins = ^Ins[25:6];

   assign mop_p0        = decode_mop(opc);
   assign misaligned_p0 = mop_misaligned(mop_p0, Result[1:0]);
   assign is_link_p0    = (opc == OP_JAL) || ((opc == OP_RFORM) && (funct == FN_JALR));
   assign start_p0      = (state == ST_IDLE) && (mop_p0 != MOP_NONE) && !misaligned_p0;
   // Fires in the MEM_TIMEOUT-th REQ cycle; counter is 0 in the first one.
   assign timeout       = (cnt == CNT_W'(MEM_TIMEOUT - 1));

   mem_align #(.DATA_W(DATA_W)) u_align (
      .st_op      (mop_p0),
      .st_addr_lo (Result[1:0]),
      .st_data    (Rdata2),
      .st_be      (be_p0),
      .st_wdata   (wdata_p0),
      .ld_op      (op_p1),
      .ld_addr_lo (addr_lo_p1),
      .ld_rdata   (rdata_p2),
      .ld_data    (ld_data)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         mem_addr   <= '0;
         mem_be     <= 4'b0000;
         mem_wdata  <= '0;
         op_p1      <= MOP_NONE;
         addr_lo_p1 <= 2'b00;
         rdata_p2   <= '0;
         bus_err_p2 <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            // p0 -> p1: request fields frozen for the whole bus transaction
            ST_IDLE: begin
               if (start_p0) begin
                  mem_addr   <= {Result[DATA_W-1:2], 2'b00};
                  mem_be     <= be_p0;
                  mem_wdata  <= wdata_p0;
                  op_p1      <= mop_p0;
                  addr_lo_p1 <= Result[1:0];
                  cnt        <= '0;
                  bus_err_p2 <= 1'b0;
               end
            end
            // p1 -> p2: ack captures read data; ack wins over a same-cycle timeout
            ST_REQ: begin
               cnt <= cnt + CNT_W'(1);
               if (mem_ack) begin
                  rdata_p2 <= mem_rdata;
               end else if (timeout) begin
                  bus_err_p2 <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      Stall     = 1'b0;
      AddrErr   = 1'b0;
      Wdata     = Result;
      case (state)
         ST_IDLE: begin
            if (mop_p0 != MOP_NONE) begin
               if (misaligned_p0) begin
                  AddrErr = !RST;
                  Wdata   = BAD_DATA;
               end else begin
                  Stall     = 1'b1;
                  state_nxt = ST_REQ;
               end
            end else if (is_link_p0) begin
               Wdata = nextPC + DATA_W'(4);
            end
         end
         ST_REQ: begin
            Stall = 1'b1;
            if (mem_ack || timeout) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            if (bus_err_p2) begin
               Wdata = BAD_DATA;
            end else if (!mop_is_store(op_p1)) begin
               Wdata = ld_data;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign mem_req = (state == ST_REQ);
   assign mem_we  = mem_req && mop_is_store(op_p1);
   assign BusErr  = (state == ST_DONE) && bus_err_p2;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes expected retire and bus
// records, monitors on the falling edge pop and compare them.
module tb_mem_stage;

   logic        CLK, RST;
   logic [31:0] Ins, Result, Rdata2, nextPC;
   logic [31:0] Wdata;
   logic        Stall, AddrErr, BusErr, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        mem_ack;

   typedef struct {
      int          id;
      logic [31:0] wdata;
      logic        aerr;
      logic        berr;
      int          stalls;
   } ret_t;

   typedef struct {
      int          id;
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } bus_t;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } dchk_t;

   ret_t  ret_q[$];
   bus_t  bus_q[$];
   dchk_t dq[$];

   int tests = 0;
   int fails = 0;
   int tid = 0;
   logic tb_vld = 1'b0;
   int ack_delay = -1;
   logic [31:0] rdata_val = 32'h0;
   int late_req = 0;

   mem_stage #(.MEM_TIMEOUT(4), .DATA_W(32)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .Ins       (Ins),
      .Result    (Result),
      .Rdata2    (Rdata2),
      .nextPC    (nextPC),
      .Wdata     (Wdata),
      .Stall     (Stall),
      .AddrErr   (AddrErr),
      .BusErr    (BusErr),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   // Memory responder: acks ack_delay cycles into a request, or once on demand.
   initial begin
      int req_cyc;
      int late_seen;
      req_cyc   = 0;
      late_seen = 0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge CLK);
         mem_ack = 1'b0;
         if (late_req != late_seen) begin
            late_seen = late_req;
            mem_ack   = 1'b1;
            mem_rdata = 32'hFFFF0000;
         end else if (mem_req) begin
            if (req_cyc == ack_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = rdata_val;
            end
            req_cyc++;
         end else begin
            req_cyc = 0;
         end
      end
   end

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   ret_t  e;
   bus_t  cur_b;
   dchk_t d;
   logic  req_seen = 1'b0;
   logic  cur_valid = 1'b0;
   int    stall_cnt = 0;

   always @(negedge CLK) begin
      while (dq.size() > 0) begin
         d = dq.pop_front();
         cmp(d.name, d.act, d.exp);
      end
      if (!RST && tb_vld) begin
         if (Stall) begin
            stall_cnt++;
         end else begin
            if (ret_q.size() == 0) begin
               cmp("unexpected_retire", 32'(!Stall), 32'h0);
            end else begin
               e = ret_q.pop_front();
               cmp($sformatf("t%0d_wdata", e.id), Wdata, e.wdata);
               cmp($sformatf("t%0d_addrerr", e.id), 32'(AddrErr), 32'(e.aerr));
               cmp($sformatf("t%0d_buserr", e.id), 32'(BusErr), 32'(e.berr));
               cmp($sformatf("t%0d_stall_cycles", e.id), 32'(stall_cnt), 32'(e.stalls));
            end
            stall_cnt = 0;
         end
      end
      if (!RST && mem_req) begin
         if (!req_seen) begin
            req_seen = 1'b1;
            if (bus_q.size() == 0) begin
               cmp("unexpected_req", 32'(mem_req), 32'h0);
            end else begin
               cur_b     = bus_q.pop_front();
               cur_valid = 1'b1;
            end
         end
         if (cur_valid) begin
            cmp($sformatf("t%0d_mem_addr", cur_b.id), mem_addr, cur_b.addr);
            cmp($sformatf("t%0d_mem_be", cur_b.id), 32'(mem_be), 32'(cur_b.be));
            cmp($sformatf("t%0d_mem_we", cur_b.id), 32'(mem_we), 32'(cur_b.we));
            if (cur_b.we) cmp($sformatf("t%0d_mem_wdata", cur_b.id), mem_wdata, cur_b.wdata);
         end
      end else begin
         req_seen  = 1'b0;
         cur_valid = 1'b0;
      end
   end

   task automatic snap(input string nm, input logic [31:0] act, input logic [31:0] exp);
      dchk_t c;
      c.name = nm;
      c.act  = act;
      c.exp  = exp;
      dq.push_back(c);
   endtask

   task automatic issue(input logic [5:0] opc, input logic [5:0] fn,
                        input logic [31:0] res, input logic [31:0] rd2,
                        input logic [31:0] npc, input logic [31:0] rdat,
                        input int ackd, input int pulse,
                        input logic [31:0] ew, input logic ea, input logic eb,
                        input int est, input logic hb, input logic [3:0] ebe,
                        input logic ewe, input logic [31:0] ebw);
      ret_t r;
      bus_t b;
      int   n;
      @(posedge CLK);
      #1;
      Ins       = {opc, 20'h00000, fn};
      Result    = res;
      Rdata2    = rd2;
      nextPC    = npc;
      rdata_val = rdat;
      ack_delay = ackd;
      tid++;
      r.id = tid; r.wdata = ew; r.aerr = ea; r.berr = eb; r.stalls = est;
      ret_q.push_back(r);
      if (hb) begin
         b.id = tid; b.addr = {res[31:2], 2'b00}; b.be = ebe; b.we = ewe; b.wdata = ebw;
         bus_q.push_back(b);
      end
      if (pulse != 0) late_req++;
      tb_vld = 1'b1;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (Stall && n < 40);
      if (Stall) snap($sformatf("t%0d_retire_timeout", tid), 32'(Stall), 32'h0);
      @(posedge CLK);
      #1;
      tb_vld = 1'b0;
      Ins    = 32'h0;
   endtask

   initial begin
      bus_t b;
      int   n;
      RST = 1'b0; Ins = 32'h0; Result = 32'h11; Rdata2 = 32'h0; nextPC = 32'h0;
      #1 RST = 1'b1;
      #1;
      snap("reset_mem_req", 32'(mem_req), 32'h0);
      snap("reset_mem_we", 32'(mem_we), 32'h0);
      snap("reset_mem_be", 32'(mem_be), 32'h0);
      snap("reset_mem_addr", mem_addr, 32'h0);
      snap("reset_mem_wdata", mem_wdata, 32'h0);
      snap("reset_stall", 32'(Stall), 32'h0);
      snap("reset_addrerr", 32'(AddrErr), 32'h0);
      snap("reset_buserr", 32'(BusErr), 32'h0);
      snap("reset_wdata_passthru", Wdata, 32'h11);
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;

      //     opc    fn     Result        Rdata2        nextPC        rdata         ack p  Wdata         ae  be  st bus be       we  wdata
      issue(6'h23, 6'h00, 32'h00000100, 32'h00000000, 32'h0,        32'h12345678, 0, 0, 32'h12345678, 0, 0, 2, 1, 4'b1111, 0, 32'h0);
      issue(6'h20, 6'h00, 32'h00000103, 32'h00000000, 32'h0,        32'h80FFFFFF, 0, 0, 32'hFFFFFF80, 0, 0, 2, 1, 4'b1000, 0, 32'h0);
      issue(6'h24, 6'h00, 32'h00000103, 32'h00000000, 32'h0,        32'h80FFFFFF, 0, 0, 32'h00000080, 0, 0, 2, 1, 4'b1000, 0, 32'h0);
      issue(6'h29, 6'h00, 32'h00000202, 32'h0000BEEF, 32'h0,        32'h0,        0, 0, 32'h00000202, 0, 0, 2, 1, 4'b1100, 1, 32'hBEEFBEEF);
      issue(6'h23, 6'h00, 32'h00000101, 32'h00000000, 32'h0,        32'h0,        0, 0, 32'hDEADBEEF, 1, 0, 0, 0, 4'b0000, 0, 32'h0);
      issue(6'h21, 6'h00, 32'h00000102, 32'h00000000, 32'h0,        32'h80017FFF, 2, 0, 32'hFFFF8001, 0, 0, 4, 1, 4'b1100, 0, 32'h0);
      issue(6'h25, 6'h00, 32'h00000100, 32'h00000000, 32'h0,        32'h8001F00D, 0, 0, 32'h0000F00D, 0, 0, 2, 1, 4'b0011, 0, 32'h0);
      issue(6'h28, 6'h00, 32'h00000401, 32'h123456A5, 32'h0,        32'h0,        0, 0, 32'h00000401, 0, 0, 2, 1, 4'b0010, 1, 32'hA5A5A5A5);
      issue(6'h2B, 6'h00, 32'h00000500, 32'hCAFEBABE, 32'h0,        32'h0,        1, 0, 32'h00000500, 0, 0, 3, 1, 4'b1111, 1, 32'hCAFEBABE);
      issue(6'h21, 6'h00, 32'h00000103, 32'h00000000, 32'h0,        32'h0,        0, 0, 32'hDEADBEEF, 1, 0, 0, 0, 4'b0000, 0, 32'h0);
      issue(6'h29, 6'h00, 32'h00000201, 32'h0000BEEF, 32'h0,        32'h0,        0, 0, 32'hDEADBEEF, 1, 0, 0, 0, 4'b0000, 0, 32'h0);
      issue(6'h20, 6'h00, 32'h00000100, 32'h00000000, 32'h0,        32'h0000007F, 0, 0, 32'h0000007F, 0, 0, 2, 1, 4'b0001, 0, 32'h0);
      issue(6'h03, 6'h00, 32'h00000055, 32'h00000000, 32'h00001000, 32'h0,        0, 0, 32'h00001004, 0, 0, 0, 0, 4'b0000, 0, 32'h0);
      issue(6'h00, 6'h09, 32'h00000055, 32'h00000000, 32'h00002000, 32'h0,        0, 0, 32'h00002004, 0, 0, 0, 0, 4'b0000, 0, 32'h0);
      issue(6'h00, 6'h21, 32'h00000077, 32'h00000000, 32'h00003000, 32'h0,        0, 0, 32'h00000077, 0, 0, 0, 0, 4'b0000, 0, 32'h0);
      issue(6'h22, 6'h00, 32'h00000123, 32'h00000000, 32'h0,        32'h0,        0, 0, 32'h00000123, 0, 0, 0, 0, 4'b0000, 0, 32'h0);
      issue(6'h23, 6'h00, 32'h00000104, 32'h00000000, 32'h0,        32'h0,       -1, 0, 32'hDEADBEEF, 0, 1, 5, 1, 4'b1111, 0, 32'h0);
      issue(6'h2B, 6'h00, 32'h00000108, 32'h11112222, 32'h0,        32'h0,       -1, 0, 32'hDEADBEEF, 0, 1, 5, 1, 4'b1111, 1, 32'h11112222);
      issue(6'h23, 6'h00, 32'h0000010C, 32'h00000000, 32'h0,        32'hA5A55A5A, 3, 0, 32'hA5A55A5A, 0, 0, 5, 1, 4'b1111, 0, 32'h0);

      // Asynchronous reset in the middle of a store request.
      @(posedge CLK);
      #1;
      Ins = {6'h2B, 26'h0}; Result = 32'h00000600; Rdata2 = 32'h13579BDF; ack_delay = -1;
      tid++;
      b.id = tid; b.addr = 32'h00000600; b.be = 4'b1111; b.we = 1'b1; b.wdata = 32'h13579BDF;
      bus_q.push_back(b);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!mem_req && n < 10);
      snap("rst_mid_req_before", 32'(mem_req), 32'h1);
      #2 RST = 1'b1;
      #1;
      snap("rst_mid_req_mem_req", 32'(mem_req), 32'h0);
      snap("rst_mid_req_mem_we", 32'(mem_we), 32'h0);
      snap("rst_mid_req_mem_be", 32'(mem_be), 32'h0);
      snap("rst_mid_req_mem_addr", mem_addr, 32'h0);
      snap("rst_mid_req_mem_wdata", mem_wdata, 32'h0);
      Ins = 32'h0;
      @(posedge CLK);
      @(negedge CLK);
      #2 RST = 1'b0;
      issue(6'h00, 6'h21, 32'hCAFE0001, 32'h00000000, 32'h0,        32'h0,       -1, 1, 32'hCAFE0001, 0, 0, 0, 0, 4'b0000, 0, 32'h0);
      issue(6'h23, 6'h00, 32'h00000700, 32'h00000000, 32'h0,        32'h0BADF00D, 0, 0, 32'h0BADF00D, 0, 0, 2, 1, 4'b1111, 0, 32'h0);

      repeat (2) @(posedge CLK);
      #1;
      snap("retire_queue_drained", 32'(ret_q.size()), 32'h0);
      snap("bus_queue_drained", 32'(bus_q.size()), 32'h0);
      repeat (3) @(negedge CLK);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, maximum cycles in REQ waiting for mem_ack before a bus error.
REQ-002 Parameter DATA_W, default 32, width of data path; only 32 is supported.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 Ins  input  32  current instruction, held stable by upstream while Stall=1.
REQ-006 Result  input  32  EX-stage ALU result; the effective address for loads and stores.
REQ-007 Rdata2  input  32  rt register value; the store data.
REQ-008 nextPC  input  32  PC of current instruction, as fed to EX.
REQ-009 Wdata  output  32  write-back value.
REQ-010 Stall  output  1  freeze PC/pipeline while high.
REQ-011 AddrErr  output  1  one-cycle pulse for a misaligned access.
REQ-012 BusErr  output  1  one-cycle pulse for a memory timeout.
REQ-013 mem_req, mem_we  output  1 each  bus request and write strobe.
REQ-014 mem_addr  output  32  word-aligned address, {Result[31:2],2'b00}.
REQ-015 mem_wdata  output  32  lane-replicated store data.
REQ-016 mem_be  output  4  byte enables, little-endian (bit0 = byte at addr+0).
REQ-017 mem_rdata  input  32  read word.
REQ-018 mem_ack  input  1  one-cycle completion for the current request.

Function
REQ-019 Memory opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B; all others are non-memory.
REQ-020 Non-memory: Wdata = Result combinationally; Stall=0; no bus activity.
REQ-021 Non-memory exception: for JAL (opcode 3) and R_FORM JALR, Wdata = nextPC+4.
REQ-022 FSM states: IDLE, REQ, DONE.
REQ-023 IDLE with an aligned memory op: Stall=1; register the address, be, wdata and op; go to REQ next edge.
REQ-024 REQ: mem_req=1 and mem_we=1 for stores; Stall=1; address/be/wdata held constant.
REQ-025 REQ exit: mem_ack=1 captures mem_rdata and moves to DONE; mem_req drops the same edge.
REQ-026 DONE: Stall=0; Wdata = extended load data (stores: Result); return to IDLE next edge.
REQ-027 Minimum memory-op latency is 3 cycles (IDLE, REQ with immediate ack, DONE).
REQ-028 Byte enables: W 4'b1111; H 4'b0011 or 4'b1100 by addr[1]; B one-hot of addr[1:0].
REQ-029 Store data: SB replicates byte x4; SH replicates half x2.
REQ-030 Load extension: LB/LH sign-extend the selected lane; LBU/LHU zero-extend.
REQ-031 Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-032 On misaligned access, remain in IDLE with no mem_req; AddrErr=1 and Stall=0 for that cycle; Wdata=32'hDEADBEEF.
REQ-033 Timeout counter clears on REQ entry and increments each REQ cycle.
REQ-034 If the count reaches MEM_TIMEOUT without mem_ack, go to DONE; BusErr=1 in DONE; Wdata=32'hDEADBEEF; a store is dropped.
REQ-035 mem_ack arriving in the same cycle the count reaches MEM_TIMEOUT wins: normal completion, no BusErr.
REQ-036 mem_ack outside REQ is ignored.

Reset
REQ-037 RST clears immediately, without waiting for CLK: state=IDLE, counter=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, captured data=0, AddrErr=0, BusErr=0.
REQ-038 RST during REQ aborts the access; a late mem_ack after release is ignored.

Structure
REQ-039 Memory opcodes, state encoding and 32'hDEADBEEF belong in the shared common_param.vh package.
REQ-040 One sub-module, mem_align: combinational be/wdata generation and load extraction/extension.

Verification
REQ-041 LW, Result=0x100, ack in first REQ cycle, rdata=0x12345678 -> Stall high 2 cycles; Wdata=0x12345678 in DONE.
REQ-042 LB, Result=0x103, rdata=0x80FFFFFF -> mem_be=4'b1000; Wdata=0xFFFFFF80. LBU with same inputs -> Wdata=0x00000080.
REQ-043 SH, Result=0x202, Rdata2=0x0000BEEF -> mem_we=1, mem_be=4'b1100, mem_wdata=0xBEEFBEEF, mem_addr=0x200.
REQ-044 LW, Result=0x101 -> no mem_req; AddrErr pulse; Stall=0; Wdata=0xDEADBEEF.
REQ-045 MEM_TIMEOUT=4, never ack -> BusErr after 4 REQ cycles; Wdata=0xDEADBEEF; FSM returns to IDLE.
REQ-046 RST asserted mid-REQ -> mem_req=0 immediately, without a clock edge; after release, an ADDU passes Result straight to Wdata.
